// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one N-pixel frame into an external filter, waits for
// the filter's result burst and forwards it to the sink, flagging count and timeout faults.
module frame_sequencer #(
    parameter int unsigned IMG_WIDTH  = 410,
    parameter int unsigned IMG_HEIGHT = 361,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TIMEOUT    = 1048575
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [DEPTH-1:0] in_pixel,
    output logic             in_ready,
    output logic [DEPTH-1:0] flt_pixel,
    output logic             flt_enable,
    output logic             flt_enable_process,
    input  logic [DEPTH-1:0] flt_image_output,
    input  logic             flt_finish,
    output logic [DEPTH-1:0] out_pixel,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             count_error,
    output logic             timeout
);

    localparam int unsigned N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_FIN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               in_ready_q, in_ready_d;
    logic [DEPTH-1:0]   flt_pixel_q, flt_pixel_d;
    logic               flt_enable_q, flt_enable_d;
    logic               flt_proc_q, flt_proc_d;
    logic [DEPTH-1:0]   out_pixel_q, out_pixel_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               count_error_q, count_error_d;
    logic               timeout_q, timeout_d;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= '0;
            out_cnt_q     <= '0;
            timer_q       <= '0;
            in_ready_q    <= 1'b0;
            flt_pixel_q   <= '0;
            flt_enable_q  <= 1'b0;
            flt_proc_q    <= 1'b0;
            out_pixel_q   <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            count_error_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            out_cnt_q     <= out_cnt_d;
            timer_q       <= timer_d;
            in_ready_q    <= in_ready_d;
            flt_pixel_q   <= flt_pixel_d;
            flt_enable_q  <= flt_enable_d;
            flt_proc_q    <= flt_proc_d;
            out_pixel_q   <= out_pixel_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            count_error_q <= count_error_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next state; level outputs are decoded from the next state so they line up with it
    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        out_cnt_d     = out_cnt_q;
        timer_d       = timer_q;
        flt_pixel_d   = flt_pixel_q;
        flt_enable_d  = 1'b0;
        out_pixel_d   = out_pixel_q;
        out_valid_d   = 1'b0;
        count_error_d = count_error_q;
        timeout_d     = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    load_cnt_d    = '0;
                    out_cnt_d     = '0;
                    timer_d       = '0;
                    count_error_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    flt_pixel_d  = in_pixel;
                    flt_enable_d = 1'b1;
                    load_cnt_d   = load_cnt_q + CNT_W'(1);
                    if (load_cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                timer_d = timer_q + TMR_W'(1);
                // The finish edge that ends the wait already carries the first result
                if (flt_finish) begin
                    out_pixel_d = flt_image_output;
                    out_valid_d = 1'b1;
                    out_cnt_d   = out_cnt_q + CNT_W'(1);
                    state_d     = S_DRAIN;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DRAIN: begin
                if (flt_finish) begin
                    out_pixel_d = flt_image_output;
                    out_valid_d = 1'b1;
                    if (out_cnt_q != CNT_W'(N + 1)) begin
                        out_cnt_d = out_cnt_q + CNT_W'(1);
                    end
                end else begin
                    count_error_d = (out_cnt_q != CNT_W'(N));
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        flt_proc_d = (state_d == S_START) || (state_d == S_WAIT_FIN) || (state_d == S_DRAIN);
    end

    assign in_ready           = in_ready_q;
    assign flt_pixel          = flt_pixel_q;
    assign flt_enable         = flt_enable_q;
    assign flt_enable_process = flt_proc_q;
    assign out_pixel          = out_pixel_q;
    assign out_valid          = out_valid_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign count_error        = count_error_q;
    assign timeout            = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: table of frame scenarios plus random frames, each
// checked against frame-level expectations derived from the sequencing rules.
module tb_frame_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned N  = W * H;
    localparam int unsigned TO = 20;
    localparam int unsigned D  = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [D-1:0] in_pixel;
    logic         in_ready;
    logic [D-1:0] flt_pixel;
    logic         flt_enable;
    logic         flt_enable_process;
    logic [D-1:0] flt_image_output;
    logic         flt_finish;
    logic [D-1:0] out_pixel;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         count_error;
    logic         timeout;

    frame_sequencer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DEPTH     (D),
        .TIMEOUT   (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .in_valid          (in_valid),
        .in_pixel          (in_pixel),
        .in_ready          (in_ready),
        .flt_pixel         (flt_pixel),
        .flt_enable        (flt_enable),
        .flt_enable_process(flt_enable_process),
        .flt_image_output  (flt_image_output),
        .flt_finish        (flt_finish),
        .out_pixel         (out_pixel),
        .out_valid         (out_valid),
        .busy              (busy),
        .done              (done),
        .count_error       (count_error),
        .timeout           (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;   // 0: back-to-back 1..N, 1: toggling valid, 2: random valid
        int d;      // finish rises d cycles after enable_process rises
        int len;    // finish high cycles
        bit spur;   // pulse start during drain
        int nout;
        bit cerr;
        bit tmo;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit           pend_xfer;
    logic [D-1:0] pend_pix;
    logic [D-1:0] flt_q[$];
    logic [D-1:0] out_q[$];
    int           done_cnt       = 0;
    int           done_cyc       = -1;
    int           first_proc_cyc = -1;
    int           strobes_at_proc = 0;
    int           proc_cnt       = 0;
    logic         proc_at_done;
    logic         busy_at_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({in_ready, flt_pixel, flt_enable, flt_enable_process, out_pixel,
                    out_valid, busy, done, count_error, timeout});
    endfunction

    // One clock: note the pending transfer, advance, then observe just after the edge
    task automatic step();
        pend_xfer = in_valid && in_ready;
        pend_pix  = in_pixel;
        @(posedge clk);
        #1;
        cyc++;
        chk("flt_enable_latency", 32'(flt_enable), 32'(pend_xfer));
        if (pend_xfer) chk("flt_pixel", 32'(flt_pixel), 32'(pend_pix));
        if (flt_enable) flt_q.push_back(flt_pixel);
        if (out_valid) out_q.push_back(out_pixel);
        if (flt_enable_process) proc_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            proc_at_done = flt_enable_process;
            busy_at_done = busy;
        end
        if (flt_enable_process && first_proc_cyc < 0) begin
            first_proc_cyc  = cyc;
            strobes_at_proc = flt_q.size();
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [D-1:0] pix[N];
        logic [D-1:0] res[$];
        int idx = 0;
        int k;
        int exp_done_k;
        for (int i = 0; i < int'(N); i++) pix[i] = (v.mode == 0) ? D'(i + 1) : D'($urandom);
        res.delete();
        for (int i = 0; i < v.len; i++) res.push_back((v.mode == 0) ? D'(101 + i) : D'($urandom));
        flt_q.delete();
        out_q.delete();
        done_cnt       = 0;
        done_cyc       = -1;
        first_proc_cyc = -1;
        proc_cnt       = 0;
        exp_done_k     = v.tmo ? int'(TO) + 1 : v.d + v.len + 1;

        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (idx < int'(N)) begin
                in_valid = (v.mode == 1) ? (c % 2 == 0) : (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                in_pixel = pix[idx];
            end else begin
                in_valid = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_pixel = D'($urandom);
            end
            k = (first_proc_cyc < 0) ? -1 : cyc - first_proc_cyc;
            flt_finish       = (k >= v.d) && (k < v.d + v.len);
            flt_image_output = flt_finish ? res[k - v.d] : D'($urandom);
            start            = v.spur && (k == v.d + 1);
            step();
            if (pend_xfer) idx++;
            if (done_cnt > 0 && k >= v.d + v.len) break;
        end
        start      = 1'b0;
        in_valid   = 1'b0;
        flt_finish = 1'b0;

        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_strobes_before_start"}, 32'(strobes_at_proc), N);
        chk({tag, "_flt_count"}, 32'(flt_q.size()), N);
        for (int i = 0; i < flt_q.size() && i < int'(N); i++)
            chk({tag, "_flt_data"}, 32'(flt_q[i]), 32'(pix[i]));
        chk({tag, "_out_count"}, 32'(out_q.size()), 32'(v.nout));
        for (int i = 0; i < out_q.size() && i < v.nout; i++)
            chk({tag, "_out_data"}, 32'(out_q[i]), 32'(res[i]));
        chk({tag, "_count_error"}, 32'(count_error), 32'(v.cerr));
        chk({tag, "_timeout"}, 32'(timeout), 32'(v.tmo));
        chk({tag, "_done_latency"}, 32'(done_cyc - first_proc_cyc), 32'(exp_done_k));
        chk({tag, "_proc_cycles"}, 32'(proc_cnt), 32'(exp_done_k));
        chk({tag, "_proc_at_done"}, 32'(proc_at_done), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd1);

        repeat (3) step();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_hold_flags"}, 32'({count_error, timeout}), 32'({v.cerr, v.tmo}));
        chk({tag, "_no_extra_done"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t rv;
        tbl[0] = '{0, 5, 12, 1'b0, 12, 1'b0, 1'b0};   // nominal
        tbl[1] = '{1, 5, 12, 1'b0, 12, 1'b0, 1'b0};   // backpressure
        tbl[2] = '{0, 99, 0, 1'b0, 0, 1'b0, 1'b1};    // finish never raised
        tbl[3] = '{0, 5, 10, 1'b0, 10, 1'b1, 1'b0};   // short result burst
        tbl[4] = '{0, 5, 12, 1'b1, 12, 1'b0, 1'b0};   // start during drain
        tbl[5] = '{0, 20, 12, 1'b0, 12, 1'b0, 1'b0};  // finish on last wait cycle
        tbl[6] = '{0, 21, 3, 1'b0, 0, 1'b0, 1'b1};    // finish one cycle too late
        tbl[7] = '{0, 1, 14, 1'b0, 14, 1'b1, 1'b0};   // results overrun N
        tbl[8] = '{2, 3, 1, 1'b0, 1, 1'b1, 1'b0};     // single result

        rst              = 1'b1;
        start            = 1'b0;
        in_valid         = 1'b0;
        in_pixel         = '0;
        flt_finish       = 1'b0;
        flt_image_output = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;

        // Noise without start must leave every output quiet
        for (int i = 0; i < 6; i++) begin
            in_valid         = 1'($urandom_range(0, 1));
            in_pixel         = D'($urandom);
            flt_finish       = 1'($urandom_range(0, 1));
            flt_image_output = D'($urandom);
            step();
            chk("quiet_before_start", all_outs(), 32'd0);
        end
        in_valid   = 1'b0;
        flt_finish = 1'b0;

        for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // Reset part way through loading
        flt_q.delete();
        done_cnt = 0;
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_pixel = D'(200 + i);
            step();
        end
        chk("midreset_loaded", 32'(flt_q.size()), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_async_outputs", all_outs(), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_pixel = D'($urandom);
            step();
            chk("midreset_quiet", all_outs(), 32'd0);
        end
        in_valid = 1'b0;
        chk("midreset_no_done", 32'(done_cnt), 32'd0);
        run_frame(tbl[0], "after_reset");

        // Random frames against the rule-level model
        for (int i = 0; i < 25; i++) begin
            rv.mode = int'($urandom_range(0, 2));
            rv.d    = int'($urandom_range(1, 24));
            rv.len  = int'($urandom_range(1, 15));
            rv.spur = 1'b0;
            if (rv.d <= int'(TO)) begin
                rv.nout = rv.len;
                rv.cerr = (rv.len != int'(N));
                rv.tmo  = 1'b0;
            end else begin
                rv.nout = 0;
                rv.cerr = 1'b0;
                rv.tmo  = 1'b1;
            end
            run_frame(rv, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
